mem_arbiter: RTL

Two-requester arbiter sharing the single unified memory of the multicycle MIPS core between the CPU's fetch/load/store port and a debug/loader port. Each requester follows a hold-until-ack handshake; the arbiter latches the winning request, drives the memory for a fixed latency and returns read data with a one-cycle ack. The CPU controller stalls (holds `pcen` low) while its `cpu_ack` is pending.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic [1:0] WE_READ = 2'b00;
  localparam logic [1:0] WE_WORD = 2'b01;
  localparam logic [1:0] WE_BYTE = 2'b10;
  localparam logic [1:0] WE_HALF = 2'b11;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DBG  = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way picker returning a one-hot winner.
// MEM_ARB_RR_EN: tie goes to the requester not granted last time;
// otherwise the CPU wins every tie.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dbg_req,
`ifdef MEM_ARB_RR_EN
  input  logic [1:0] last_gnt,
`endif
  output logic [1:0] winner
);

  // Lone requester always wins; only ties consult the policy.
  always_comb begin
    winner = GNT_NONE;
    if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_gnt == GNT_CPU) ? GNT_DBG : GNT_CPU;
`else
      winner = GNT_CPU;
`endif
    end else if (cpu_req) begin
      winner = GNT_CPU;
    end else if (dbg_req) begin
      winner = GNT_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory between the CPU port and a debug/loader
// port. Optional round-robin tie-break is enabled by MEM_ARB_RR_EN.
//
//   state  | meaning
//   IDLE   | no owner; sample requests, latch winner into mem_* outputs
//   ACCESS | memory driven for MEM_LAT cycles; write strobe in first cycle only
//   RESP   | one-cycle ack to the owner; rdata register valid
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [1:0]        dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt,
  output logic [1:0]        arb_state
);

  localparam int                CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_we_q, mem_we_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [1:0]        winner;

`ifdef MEM_ARB_RR_EN
  logic [1:0]        last_gnt_q, last_gnt_d;
`endif

  arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
`ifdef MEM_ARB_RR_EN
    .last_gnt (last_gnt_q),
`endif
    .winner   (winner)
  );

  // Next-state, counter and datapath register updates.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = WE_READ;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_gnt_d  = last_gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (winner != GNT_NONE) begin
          state_d = ACCESS;
          gnt_d   = winner;
          cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
          last_gnt_d = winner;
`endif
          if (winner == GNT_CPU) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_we;
          end else begin
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            mem_we_d    = dbg_we;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          if (gnt_q == GNT_CPU) begin
            cpu_rdata_d = mem_rdata;
            cpu_ack_d   = 1'b1;
          end else begin
            dbg_rdata_d = mem_rdata;
            dbg_ack_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_NONE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= WE_READ;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_gnt_q  <= GNT_DBG;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
`ifdef MEM_ARB_RR_EN
      last_gnt_q  <= last_gnt_d;
`endif
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign gnt       = gnt_q;
  assign arb_state = state_q;

endmodule
